// File: rtl/vga_timing_lookahead_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_lookahead_pkg
// Purpose  : Default VGA 640x480@60 raster timing, derived totals/widths,
//            the drawing-pipeline depth and a shared raster position type.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_lookahead_pkg;

    localparam int H_VISIBLE_AREA  = 640;
    localparam int H_FRONT_PORCH   = 16;
    localparam int H_SYNC_PULSE    = 96;
    localparam int H_BACK_PORCH    = 48;
    localparam int V_VISIBLE_AREA  = 480;
    localparam int V_FRONT_PORCH   = 10;
    localparam int V_SYNC_PULSE    = 2;
    localparam int V_BACK_PORCH    = 33;

    localparam int H_WHOLE_LINE  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_WHOLE_LINE  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW            = $clog2(H_WHOLE_LINE);
    localparam int VW            = $clog2(V_WHOLE_LINE);

    // Depth of the drawing_logic pipeline; the aot coordinates lead by this much.
    localparam int PIPELINE_STAGES = 2;

    typedef struct packed {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
    } vga_pos_t;

    // True when lo <= v < lo+len.
    function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                       input int unsigned len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_raster_counter.sv
`default_nettype none
// ============================================================================
// Module   : vga_raster_counter
// Purpose  : Raster (x,y) position counter with a programmable reset
//            position. Exposes both the registered position and the value it
//            will take on the next clock so callers can register decodes that
//            line up with the position.
// Revision : 1.0 - initial release
// ============================================================================
module vga_raster_counter
    import vga_timing_lookahead_pkg::*;
#(
    parameter int  H_TOTAL = H_WHOLE_LINE,
    parameter int  V_TOTAL = V_WHOLE_LINE,
    parameter int  RESET_X = 0,
    parameter int  RESET_Y = 0,
    parameter int  X_W     = HW,
    parameter int  Y_W     = VW,
    parameter type pos_t   = vga_pos_t
) (
    input  logic vga_pix_clk,
    input  logic rst_n,
    input  logic en,
    output pos_t pos,
    output pos_t pos_next
);

    localparam logic [X_W-1:0] c_X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] c_X_RST  = X_W'(RESET_X);
    localparam logic [Y_W-1:0] c_Y_RST  = Y_W'(RESET_Y);

    pos_t r_pos;

    // Next position: hold when disabled, otherwise step along the raster.
    always_comb begin
        pos_next = r_pos;
        if (en) begin
            if (r_pos.x == c_X_LAST) begin
                pos_next.x = '0;
                if (r_pos.y == c_Y_LAST) begin
                    pos_next.y = '0;
                end else begin
                    pos_next.y = r_pos.y + Y_W'(1);
                end
            end else begin
                pos_next.x = r_pos.x + X_W'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos.x <= c_X_RST;
            r_pos.y <= c_Y_RST;
        end else begin
            r_pos <= pos_next;
        end
    end

    assign pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/vga_timing_lookahead.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_lookahead
// Purpose  : Parametrised VGA timing generator. Drives beam position, syncs
//            and display enable, plus a second coordinate set running
//            LOOKAHEAD pixels ahead for pipelined drawing logic, with line and
//            frame strobes and a completed-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_lookahead
    import vga_timing_lookahead_pkg::*;
#(
    parameter int   H_VISIBLE_AREA = 640,
    parameter int   H_FRONT_PORCH  = 16,
    parameter int   H_SYNC_PULSE   = 96,
    parameter int   H_BACK_PORCH   = 48,
    parameter int   V_VISIBLE_AREA = 480,
    parameter int   V_FRONT_PORCH  = 10,
    parameter int   V_SYNC_PULSE   = 2,
    parameter int   V_BACK_PORCH   = 33,
    parameter logic H_SYNC_POL     = 1'b0,
    parameter logic V_SYNC_POL     = 1'b0,
    parameter int   LOOKAHEAD      = PIPELINE_STAGES,
    parameter int   FRAME_CNT_W    = 16,
    localparam int  H_WHOLE = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int  V_WHOLE = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int  SX_W    = $clog2(H_WHOLE),
    localparam int  SY_W    = $clog2(V_WHOLE)
) (
    input  logic                   vga_pix_clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic [SX_W-1:0]        sx,
    output logic [SY_W-1:0]        sy,
    output logic                   display_enabled,
    output logic                   H_SYNC,
    output logic                   V_SYNC,
    output logic [SX_W-1:0]        sx_aot,
    output logic [SY_W-1:0]        sy_aot,
    output logic                   de_aot,
    output logic                   line_stb_aot,
    output logic                   frame_stb_aot,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int unsigned    c_HS_START  = H_VISIBLE_AREA + H_FRONT_PORCH;
    localparam int unsigned    c_VS_START  = V_VISIBLE_AREA + V_FRONT_PORCH;
    localparam logic [SX_W-1:0] c_X_LAST   = SX_W'(H_WHOLE - 1);
    localparam logic [SY_W-1:0] c_Y_LAST   = SY_W'(V_WHOLE - 1);
    localparam logic           c_DE_AOT_RST = (LOOKAHEAD < H_VISIBLE_AREA);

    // The lookahead must stay inside the first line so the aot reset
    // position is (LOOKAHEAD, 0).
    if (LOOKAHEAD < 0 || LOOKAHEAD >= H_WHOLE) begin : g_bad_lookahead
        $error("vga_timing_lookahead: LOOKAHEAD out of range 0..H_WHOLE_LINE-1");
    end

    typedef struct packed {
        logic [SX_W-1:0] x;
        logic [SY_W-1:0] y;
    } pos_t;

    pos_t w_cur;
    pos_t w_cur_next;
    pos_t w_aot;
    pos_t w_aot_next;

    logic w_de_next;
    logic w_hs_next;
    logic w_vs_next;
    logic w_de_aot_next;
    logic w_frame_wrap;

    logic                   r_de;
    logic                   r_hsync;
    logic                   r_vsync;
    logic                   r_de_aot;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    vga_raster_counter #(
        .H_TOTAL (H_WHOLE),
        .V_TOTAL (V_WHOLE),
        .RESET_X (0),
        .RESET_Y (0),
        .X_W     (SX_W),
        .Y_W     (SY_W),
        .pos_t   (pos_t)
    ) u_cur (
        .vga_pix_clk (vga_pix_clk),
        .rst_n       (rst_n),
        .en          (en),
        .pos         (w_cur),
        .pos_next    (w_cur_next)
    );

    // Independent counter seeded LOOKAHEAD ahead; never derived from sx/sy.
    vga_raster_counter #(
        .H_TOTAL (H_WHOLE),
        .V_TOTAL (V_WHOLE),
        .RESET_X (LOOKAHEAD),
        .RESET_Y (0),
        .X_W     (SX_W),
        .Y_W     (SY_W),
        .pos_t   (pos_t)
    ) u_aot (
        .vga_pix_clk (vga_pix_clk),
        .rst_n       (rst_n),
        .en          (en),
        .pos         (w_aot),
        .pos_next    (w_aot_next)
    );

    // Decode from the next position so the registered flags match sx/sy.
    assign w_de_next     = in_window(32'(w_cur_next.x), 0, H_VISIBLE_AREA)
                         && in_window(32'(w_cur_next.y), 0, V_VISIBLE_AREA);
    assign w_hs_next     = in_window(32'(w_cur_next.x), c_HS_START, H_SYNC_PULSE);
    assign w_vs_next     = in_window(32'(w_cur_next.y), c_VS_START, V_SYNC_PULSE);
    assign w_de_aot_next = in_window(32'(w_aot_next.x), 0, H_VISIBLE_AREA)
                         && in_window(32'(w_aot_next.y), 0, V_VISIBLE_AREA);
    assign w_frame_wrap  = en && (w_cur.x == c_X_LAST) && (w_cur.y == c_Y_LAST);

    // Registered display enable and syncs.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de     <= 1'b1;
            r_hsync  <= ~H_SYNC_POL;
            r_vsync  <= ~V_SYNC_POL;
            r_de_aot <= c_DE_AOT_RST;
        end else begin
            r_de     <= w_de_next;
            r_hsync  <= w_hs_next ? H_SYNC_POL : ~H_SYNC_POL;
            r_vsync  <= w_vs_next ? V_SYNC_POL : ~V_SYNC_POL;
            r_de_aot <= w_de_aot_next;
        end
    end

    // Completed-frame counter, bumped as the beam leaves the last pixel.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        end
    end

    assign sx              = w_cur.x;
    assign sy              = w_cur.y;
    assign display_enabled = r_de;
    assign H_SYNC          = r_hsync;
    assign V_SYNC          = r_vsync;
    assign sx_aot          = w_aot.x;
    assign sy_aot          = w_aot.y;
    assign de_aot          = r_de_aot;
    assign frame_cnt       = r_frame_cnt;

    // Strobes are qualified by en so they last exactly one enabled cycle.
    assign line_stb_aot    = en && (w_aot.x == '0);
    assign frame_stb_aot   = en && (w_aot.x == '0) && (w_aot.y == '0);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_lookahead.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_lookahead
// Purpose  : Self-checking bench for vga_timing_lookahead. Three builds share
//            clock, reset and enable: default 640x480 with LOOKAHEAD=2, a tiny
//            raster with LOOKAHEAD at its maximum and active-high syncs, and a
//            tiny raster with LOOKAHEAD=0. A reference model tracks only the
//            number of enabled pixel steps since reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_lookahead;

    logic clk;
    logic rst_n;
    logic en;

    logic [9:0]  a_sx, a_sx_aot;
    logic [9:0]  a_sy, a_sy_aot;
    logic        a_de, a_hs, a_vs, a_de_aot, a_ls, a_fs;
    logic [15:0] a_fc;

    logic [3:0]  b_sx, b_sx_aot;
    logic [2:0]  b_sy, b_sy_aot;
    logic        b_de, b_hs, b_vs, b_de_aot, b_ls, b_fs;
    logic [3:0]  b_fc;

    logic [3:0]  c_sx, c_sx_aot;
    logic [2:0]  c_sy, c_sy_aot;
    logic        c_de, c_hs, c_vs, c_de_aot, c_ls, c_fs;
    logic [3:0]  c_fc;

    int    n_cmp  = 0;
    int    n_fail = 0;
    longint n_adv = 0;
    bit    check_on = 1'b0;

    vga_timing_lookahead dut_a (
        .vga_pix_clk(clk), .rst_n(rst_n), .en(en),
        .sx(a_sx), .sy(a_sy), .display_enabled(a_de), .H_SYNC(a_hs), .V_SYNC(a_vs),
        .sx_aot(a_sx_aot), .sy_aot(a_sy_aot), .de_aot(a_de_aot),
        .line_stb_aot(a_ls), .frame_stb_aot(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LOOKAHEAD(14), .FRAME_CNT_W(4)
    ) dut_b (
        .vga_pix_clk(clk), .rst_n(rst_n), .en(en),
        .sx(b_sx), .sy(b_sy), .display_enabled(b_de), .H_SYNC(b_hs), .V_SYNC(b_vs),
        .sx_aot(b_sx_aot), .sy_aot(b_sy_aot), .de_aot(b_de_aot),
        .line_stb_aot(b_ls), .frame_stb_aot(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(2),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .LOOKAHEAD(0), .FRAME_CNT_W(4)
    ) dut_c (
        .vga_pix_clk(clk), .rst_n(rst_n), .en(en),
        .sx(c_sx), .sy(c_sy), .display_enabled(c_de), .H_SYNC(c_hs), .V_SYNC(c_vs),
        .sx_aot(c_sx_aot), .sy_aot(c_sy_aot), .de_aot(c_de_aot),
        .line_stb_aot(c_ls), .frame_stb_aot(c_fs), .frame_cnt(c_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: everything follows from the count of enabled steps since reset.
    task automatic check_inst(
        input string tag, input longint n,
        input int hva, hfp, hsp, hbp, vva, vfp, vsp, vbp,
        input bit hpol, vpol, input int la, fw, input bit en_v,
        input longint o_sx, o_sy, input bit o_de, o_hs, o_vs,
        input longint o_sxa, o_sya, input bit o_dea, o_ls, o_fs, input longint o_fc);
        longint h, v, tot, lin, alin, x, y, ax, ay;
        h    = hva + hfp + hsp + hbp;
        v    = vva + vfp + vsp + vbp;
        tot  = h * v;
        lin  = n % tot;
        alin = (n + la) % tot;
        x = lin % h;   y = lin / h;
        ax = alin % h; ay = alin / h;
        cmp({tag, "_sx"}, o_sx, x);
        cmp({tag, "_sy"}, o_sy, y);
        cmp({tag, "_de"}, o_de, (x < hva && y < vva) ? 1 : 0);
        cmp({tag, "_hsync"}, o_hs, (x >= hva + hfp && x < hva + hfp + hsp) ? hpol : !hpol);
        cmp({tag, "_vsync"}, o_vs, (y >= vva + vfp && y < vva + vfp + vsp) ? vpol : !vpol);
        cmp({tag, "_sx_aot"}, o_sxa, ax);
        cmp({tag, "_sy_aot"}, o_sya, ay);
        cmp({tag, "_de_aot"}, o_dea, (ax < hva && ay < vva) ? 1 : 0);
        cmp({tag, "_line_stb"}, o_ls, (en_v && ax == 0) ? 1 : 0);
        cmp({tag, "_frame_stb"}, o_fs, (en_v && ax == 0 && ay == 0) ? 1 : 0);
        cmp({tag, "_frame_cnt"}, o_fc, (n / tot) % (longint'(1) << fw));
    endtask

    // Step counter: async clear, advances only on enabled edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_adv <= 0;
        else if (en) n_adv <= n_adv + 1;
    end

    // Compare every instance against the model, mid-cycle.
    always @(negedge clk) begin
        if (check_on) begin
            check_inst("a", n_adv, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2, 16, en,
                       a_sx, a_sy, a_de, a_hs, a_vs, a_sx_aot, a_sy_aot, a_de_aot, a_ls, a_fs, a_fc);
            check_inst("b", n_adv, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1, 1'b1, 14, 4, en,
                       b_sx, b_sy, b_de, b_hs, b_vs, b_sx_aot, b_sy_aot, b_de_aot, b_ls, b_fs, b_fc);
            check_inst("c", n_adv, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 0, 4, en,
                       c_sx, c_sy, c_de, c_hs, c_vs, c_sx_aot, c_sy_aot, c_de_aot, c_ls, c_fs, c_fc);
            cmp("c_aot_x_tracks_sx", c_sx_aot, c_sx);
            cmp("c_aot_y_tracks_sy", c_sy_aot, c_sy);
        end
    end

    initial begin
        bit found;
        int hs_low, hs_min, hs_max, de_low;
        longint old_fc;

        en    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset values, hand computed.
        cmp("rst_a_sx", a_sx, 0);
        cmp("rst_a_sy", a_sy, 0);
        cmp("rst_a_sx_aot", a_sx_aot, 2);
        cmp("rst_a_hsync", a_hs, 1);
        cmp("rst_a_vsync", a_vs, 1);
        cmp("rst_a_de", a_de, 1);
        cmp("rst_a_frame_cnt", a_fc, 0);
        cmp("rst_b_sx_aot", b_sx_aot, 14);
        cmp("rst_b_de_aot", b_de_aot, 0);
        cmp("rst_b_hsync", b_hs, 0);
        check_on = 1'b1;
        rst_n    = 1'b1;

        // Run to (797,10) on the default raster.
        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(posedge clk); #1;
            if (a_sx == 10'd797 && a_sy == 10'd10) found = 1'b1;
        end
        cmp("reach_797_10", found, 1);
        @(posedge clk); #1;
        cmp("lit_sx_aot_wrap", a_sx_aot, 0);
        cmp("lit_sy_aot_wrap", a_sy_aot, 11);
        cmp("lit_line_stb", a_ls, 1);
        repeat (2) @(posedge clk); #1;
        cmp("lit_sx_new_line", a_sx, 0);
        cmp("lit_sy_new_line", a_sy, 11);

        // Scan one visible line.
        hs_low = 0; hs_min = 9999; hs_max = -1; de_low = 0;
        for (int i = 0; i < 800; i++) begin
            if (a_hs == 1'b0) begin
                hs_low++;
                if (int'(a_sx) < hs_min) hs_min = int'(a_sx);
                if (int'(a_sx) > hs_max) hs_max = int'(a_sx);
            end
            if (a_de == 1'b0) de_low++;
            @(posedge clk); #1;
        end
        cmp("scan_hsync_cycles", hs_low, 96);
        cmp("scan_hsync_first", hs_min, 656);
        cmp("scan_hsync_last", hs_max, 751);
        cmp("scan_de_low_cycles", de_low, 160);

        // Frame wrap on the tiny raster.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (b_sx == 4'd14 && b_sy == 3'd7) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        cmp("reach_b_last_pixel", found, 1);
        old_fc = b_fc;
        @(posedge clk); #1;
        cmp("lit_b_wrap_sx", b_sx, 0);
        cmp("lit_b_wrap_sy", b_sy, 0);
        cmp("lit_b_frame_cnt", b_fc, (old_fc + 1) % 16);
        cmp("lit_c_frame_stb_origin", c_fs, 1);

        // 25% duty enable, as from a 100 MHz clock.
        for (int i = 0; i < 4000; i++) begin
            en = (i % 4 == 0);
            @(posedge clk); #1;
        end

        // Random enable with a mid-frame asynchronous reset.
        for (int i = 0; i < 12000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if (i == 6000) begin
                #1 rst_n = 1'b0;
                #1;
                cmp("async_rst_a_sx", a_sx, 0);
                cmp("async_rst_a_sy", a_sy, 0);
                cmp("async_rst_a_sx_aot", a_sx_aot, 2);
                cmp("async_rst_a_hsync", a_hs, 1);
                cmp("async_rst_a_frame_cnt", a_fc, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end

        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
